// File: rtl/adder_tree_pkg.sv
// Shared types and constants for the adder tree front end.
// Holds default sizes, the collector state enum and the frame bus width.
package adder_tree_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NUM_IN = 8;
  localparam int FRAME_W    = DEF_WIDTH * DEF_NUM_IN;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } coll_state_t;

endpackage

// File: rtl/frame_hold_reg.sv
// Single-entry hold register with load/drain/valid tracking.
// A load on the same edge as a drain keeps valid high (no bubble).
module frame_hold_reg
  import adder_tree_pkg::*;
#(
  parameter int W = FRAME_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q
);

  // Capture a new frame on load, drop valid once the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/operand_collector.sv
// Packs a serial operand stream into NUM_IN-wide frames for the adder tree.
// Optional macro OPCOLL_FRAME_CNT_EN adds frame_id and overflow_seen outputs.
module operand_collector
  import adder_tree_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int CNT_W  = $clog2(NUM_IN) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [NUM_IN*WIDTH-1:0] out_data,
  output logic                    out_valid,
  output logic                    out_short,
  input  logic                    out_ready,
`ifdef OPCOLL_FRAME_CNT_EN
  output logic [15:0]             frame_id,
  output logic [0:0]              overflow_seen,
`endif
  output logic [CNT_W-1:0]        fill_cnt
);

  localparam int FW = NUM_IN * WIDTH;

  coll_state_t state, state_nx;

  logic [FW-1:0]    fill;
  logic [FW-1:0]    merged;
  logic [FW:0]      load_frame;
  logic [FW:0]      hold_q;
  logic             pend_short;
  logic             xfer;
  logic             at_end;
  logic             close;
  logic             drain;
  logic             hold_free;
  logic             load;
  logic             early;

  assign in_ready  = (state == FILL) && !rst;
  assign xfer      = in_valid && in_ready;
  assign at_end    = fill_cnt == CNT_W'(NUM_IN - 1);
  assign close     = xfer && (at_end || in_last);
  assign early     = in_last && !at_end;
  assign drain     = out_valid && out_ready;
  assign hold_free = !out_valid || out_ready;

  // Fill register contents with the incoming operand written in place.
  always_comb begin
    merged = fill;
    for (int k = 0; k < NUM_IN; k++) begin
      if (xfer && fill_cnt == CNT_W'(k)) begin
        merged[k*WIDTH +: WIDTH] = in_data;
      end
    end
  end

  // Select what enters the hold register and when.
  always_comb begin
    load       = 1'b0;
    load_frame = {early, merged};
    if (state == PEND) begin
      load       = drain;
      load_frame = {pend_short, fill};
    end else begin
      load = close && hold_free;
    end
  end

  // Next-state logic: park in PEND while a closed frame waits for space.
  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (close && !hold_free) state_nx = PEND;
      PEND:    if (drain) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  // Fill register, slot counter and short flag of a parked frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill       <= '0;
      fill_cnt   <= '0;
      pend_short <= 1'b0;
    end else if (load) begin
      fill       <= '0;
      fill_cnt   <= '0;
      pend_short <= 1'b0;
    end else if (close) begin
      fill       <= merged;
      pend_short <= early;
    end else if (xfer) begin
      fill     <= merged;
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  frame_hold_reg #(
    .W(FW + 1)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    (load_frame),
    .ready(out_ready),
    .valid(out_valid),
    .q    (hold_q)
  );

  assign out_data  = hold_q[FW-1:0];
  assign out_short = hold_q[FW];

`ifdef OPCOLL_FRAME_CNT_EN
  // Count drained frames and remember any operand offered while parked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_id      <= '0;
      overflow_seen <= 1'b0;
    end else begin
      if (drain) frame_id <= frame_id + 16'd1;
      if (state == PEND && in_valid) overflow_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_collector.sv
// Self-checking bench for operand_collector.
// Table vectors, directed sequences and a random run against a frame model.
module tb_operand_collector;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_short;
  logic          out_ready = 1'b0;
  logic [CW-1:0] fill_cnt;
`ifdef OPCOLL_FRAME_CNT_EN
  logic [15:0]   frame_id;
  logic [0:0]    overflow_seen;
`endif

  int checks = 0;
  int failures = 0;

  operand_collector dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_short(out_short),
    .out_ready(out_ready),
`ifdef OPCOLL_FRAME_CNT_EN
    .frame_id     (frame_id),
    .overflow_seen(overflow_seen),
`endif
    .fill_cnt (fill_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: frame-level view of collector
  logic [7:0]  m_cur[$];
  bit          m_hold_v;
  logic [63:0] m_hold_d;
  bit          m_hold_s;
  bit          m_pend_v;
  logic [63:0] m_pend_d;
  bit          m_pend_s;
  int          m_pend_n;
  int          m_drains;
  bit          m_ovf;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur.delete();
    m_hold_v = 0; m_hold_d = '0; m_hold_s = 0;
    m_pend_v = 0; m_pend_d = '0; m_pend_s = 0; m_pend_n = 0;
    m_drains = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit iv, input bit il,
                            input logic [7:0] d, input bit ordy);
    bit drain;
    bit nv;
    logic [63:0] f;
    drain = m_hold_v && ordy;
    if (drain) m_drains++;
    nv = m_hold_v && !drain;
    if (m_pend_v) begin
      if (iv) m_ovf = 1;
      if (drain) begin
        m_hold_d = m_pend_d; m_hold_s = m_pend_s;
        nv = 1; m_pend_v = 0;
      end
    end else if (iv) begin
      m_cur.push_back(d);
      if (m_cur.size() == N || il) begin
        f = '0;
        foreach (m_cur[i]) f[i*8 +: 8] = m_cur[i];
        if (!nv) begin
          m_hold_d = f; m_hold_s = m_cur.size() < N; nv = 1;
        end else begin
          m_pend_v = 1; m_pend_d = f;
          m_pend_s = m_cur.size() < N; m_pend_n = m_cur.size();
        end
        m_cur.delete();
      end
    end
    m_hold_v = nv;
  endtask

  task automatic model_cmp();
    int ec;
    ec = m_pend_v ? m_pend_n - 1 : m_cur.size();
    chk("out_valid", 64'(out_valid), 64'(m_hold_v));
    chk("in_ready", 64'(in_ready), 64'(!m_pend_v));
    chk("fill_cnt", 64'(fill_cnt), 64'(ec));
    if (m_hold_v) begin
      chk("out_data", out_data, m_hold_d);
      chk("out_short", 64'(out_short), 64'(m_hold_s));
    end
`ifdef OPCOLL_FRAME_CNT_EN
    chk("frame_id", 64'(frame_id), 64'(m_drains % 65536));
    chk("overflow_seen", 64'(overflow_seen), 64'(m_ovf));
`endif
  endtask

  // One cycle: drive at posedge+1, model the edge, check at next posedge+1
  task automatic step(input bit iv, input bit il,
                      input logic [7:0] d, input bit ordy);
    in_valid = iv; in_last = il; in_data = d; out_ready = ordy;
    @(posedge clk);
    model_edge(iv, il, d, ordy);
    #1;
    model_cmp();
  endtask

  typedef struct {
    bit          iv;
    bit          il;
    logic [7:0]  d;
    bit          ordy;
    bit          e_ov;
    logic [63:0] e_od;
    bit          e_sh;
    bit          e_ir;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   pulses;

  initial begin
    vec_t v;
    model_reset();

    // Full frame 01..08
    for (int i = 0; i < 8; i++) begin
      v = '{1, 0, 8'(i + 1), 1, i == 7, 64'h0807060504030201, 0, 1,
            i == 7 ? 0 : i + 1};
      tbl.push_back(v);
    end
    // Short frame AA BB CC
    tbl.push_back('{1, 0, 8'hAA, 1, 0, 64'h0, 0, 1, 1});
    tbl.push_back('{1, 0, 8'hBB, 1, 0, 64'h0, 0, 1, 2});
    tbl.push_back('{1, 1, 8'hCC, 1, 1, 64'h0000000000CCBBAA, 1, 1, 0});
    // in_last without in_valid is ignored
    tbl.push_back('{0, 1, 8'h55, 1, 0, 64'h0, 0, 1, 0});
    // Full frame with in_last on the 8th operand: not short
    for (int i = 0; i < 8; i++) begin
      v = '{1, i == 7, 8'(8'hF0 + i), 1, i == 7, 64'hF7F6F5F4F3F2F1F0, 0,
            1, i == 7 ? 0 : i + 1};
      tbl.push_back(v);
    end

    // Reset state
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fill_cnt", 64'(fill_cnt), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_short", 64'(out_short), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table vectors
    foreach (tbl[i]) begin
      step(tbl[i].iv, tbl[i].il, tbl[i].d, tbl[i].ordy);
      chk($sformatf("tbl%0d_ov", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_ir", i), 64'(in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_cnt", i), 64'(fill_cnt), 64'(tbl[i].e_cnt));
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d_od", i), out_data, tbl[i].e_od);
        chk($sformatf("tbl%0d_sh", i), 64'(out_short), 64'(tbl[i].e_sh));
      end
    end
    step(0, 0, 0, 1);

    // Backpressure: two full frames, second parks in PEND
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h10 + i), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'hEE, 0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_fill_cnt", 64'(fill_cnt), 64'd7);
    chk("bp_hold1", out_data, 64'h1716151413121110);
    step(0, 0, 0, 1);
    chk("bp_nobubble", 64'(out_valid), 64'd1);
    chk("bp_hold2", out_data, 64'h1F1E1D1C1B1A1918);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    step(0, 0, 0, 1);

    // Streaming: 64 operands, one frame every 8 cycles
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      step(1, 0, 8'($urandom), 1);
      if (out_valid) pulses++;
    end
    chk("stream_pulses", 64'(pulses), 64'd8);
    step(0, 0, 0, 1);

    // Async reset after 5 operands, asserted between edges
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h30 + i), 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_fill_cnt", 64'(fill_cnt), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
`ifdef OPCOLL_FRAME_CNT_EN
    chk("arst_frame_id", 64'(frame_id), 64'd0);
    chk("arst_overflow", 64'(overflow_seen), 64'd0);
`endif
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h40 + i), 1);
    chk("arst_fresh", out_data, 64'h4746454443424140);
    step(0, 0, 0, 1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
           8'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
